// File: rtl/hdmi_ddc_pkg.sv
// Shared definitions for the HDMI DDC EDID responder.
// Contents: responder FSM state encoding, default target address, EDID geometry.
package hdmi_ddc_pkg;

  localparam int unsigned EDID_SIZE = 256;
  localparam int unsigned EDID_AW   = 8;
  localparam int unsigned BYTE_W    = 8;

  localparam logic [6:0] DDC_DEF_ADDR = 7'h50;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_RD_WAIT
  } ddc_state_t;

endpackage

// File: rtl/i2c_line_filter.sv
// Synchronizer, majority-free run-length glitch filter and edge strobes for
// one I2C line. A new level is accepted only after FILTER_LEN consecutive
// synchronized samples disagree with the current filtered level.
// Ports:
//   clk_i   system clock
//   rst_i   synchronous active-high reset (filtered level resets to 1)
//   line_i  raw pad level
//   level_o filtered level
//   rise_o  one-cycle pulse when the filtered level goes 0->1
//   fall_o  one-cycle pulse when the filtered level goes 1->0
module i2c_line_filter
  import hdmi_ddc_pkg::*;
#(
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CNT_W = 3;

  logic             sync0_q, sync1_q;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count disagreeing samples; any agreeing sample restarts the run.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (sync1_q != level_q) begin
      if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
        level_d = sync1_q;
        rise_d  = sync1_q;
        fall_d  = ~sync1_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync0_q <= 1'b1;
      sync1_q <= 1'b1;
      level_q <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync0_q <= line_i;
      sync1_q <= sync0_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/hdmi_ddc_edid_responder.sv
// I2C target on the HDMI DDC bus serving a 256-byte EDID image.
// Optional feature: define DDC_I2C_WRITE_EN to let I2C data bytes update the
// image; otherwise they are ACKed and advance the offset but are discarded.
// Ports:
//   aclk_i, rst_i                 clock, synchronous active-high reset
//   i2c_scl_i, i2c_sda_i          bus levels from the IOBUF
//   i2c_sda_o, i2c_sda_t_o        open-drain drive (o=0, t=1 releases)
//   mem_we_i/addr_i/wdata_i       host byte-write port into the image
//   busy_o                        address-matched transaction in progress
//   xfer_done_o                   one-cycle pulse on STOP ending a matched transfer
//   offset_o                      current word offset pointer
module hdmi_ddc_edid_responder
  import hdmi_ddc_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR   = DDC_DEF_ADDR,
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic               aclk_i,
  input  logic               rst_i,
  input  logic               i2c_scl_i,
  input  logic               i2c_sda_i,
  output logic               i2c_sda_o,
  output logic               i2c_sda_t_o,
  input  logic               mem_we_i,
  input  logic [EDID_AW-1:0] mem_addr_i,
  input  logic [BYTE_W-1:0]  mem_wdata_i,
  output logic               busy_o,
  output logic               xfer_done_o,
  output logic [EDID_AW-1:0] offset_o
);

  localparam int unsigned BCNT_W = 4;

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start_c, stop_c, addr_match_c;

  ddc_state_t         state_q, state_d;
  logic [BYTE_W-1:0]  shift_q, shift_d;
  logic [BCNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [EDID_AW-1:0] offset_q, offset_d, offset_inc_c;
  logic               rw_q, rw_d;
  logic               first_q, first_d;
  logic               sda_t_q, sda_t_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
`ifdef DDC_I2C_WRITE_EN
  logic               i2c_we_c;
`endif

  logic [BYTE_W-1:0] mem_q [EDID_SIZE];

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .clk_i(aclk_i), .rst_i(rst_i), .line_i(i2c_scl_i),
    .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .clk_i(aclk_i), .rst_i(rst_i), .line_i(i2c_sda_i),
    .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall)
  );

  assign start_c      = sda_fall & scl_lvl;
  assign stop_c       = sda_rise & scl_lvl;
  assign addr_match_c = (shift_q[7:1] == DEV_ADDR);
  assign offset_inc_c = offset_q + EDID_AW'(1);

  // State register
  always_ff @(posedge aclk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state: ACK phases hand over on the 9th SCL rise, data phases on the
  // falling edge after their 8th bit.
  always_comb begin
    state_d = state_q;
    if (start_c) begin
      state_d = ST_ADDR;
    end else if (stop_c) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_ADDR:     if (scl_fall && bit_cnt_q == BCNT_W'(8))
                       state_d = addr_match_c ? ST_ADDR_ACK : ST_IDLE;
        ST_ADDR_ACK: if (scl_rise) state_d = rw_q ? ST_RD_DATA : ST_WR_DATA;
        ST_WR_DATA:  if (scl_fall && bit_cnt_q == BCNT_W'(8)) state_d = ST_WR_ACK;
        ST_WR_ACK:   if (scl_rise) state_d = ST_WR_DATA;
        ST_RD_DATA:  if (scl_fall && bit_cnt_q == BCNT_W'(8)) state_d = ST_RD_ACK;
        ST_RD_ACK:   if (scl_rise) state_d = sda_lvl ? ST_RD_WAIT : ST_RD_DATA;
        default:     state_d = state_q;
      endcase
    end
  end

  // Datapath and output next values
  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    offset_d  = offset_q;
    rw_d      = rw_q;
    first_d   = first_q;
    sda_t_d   = sda_t_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
`ifdef DDC_I2C_WRITE_EN
    i2c_we_c  = 1'b0;
`endif
    if (start_c) begin
      bit_cnt_d = '0;
      sda_t_d   = 1'b1;
    end else if (stop_c) begin
      bit_cnt_d = '0;
      sda_t_d   = 1'b1;
      busy_d    = 1'b0;
      done_d    = busy_q;
    end else begin
      unique case (state_q)
        ST_ADDR, ST_WR_DATA: begin
          if (scl_rise && bit_cnt_q < BCNT_W'(8)) begin
            shift_d   = {shift_q[6:0], sda_lvl};
            bit_cnt_d = bit_cnt_q + BCNT_W'(1);
          end
          if (scl_fall) begin
            sda_t_d = 1'b1;
            if (bit_cnt_q == BCNT_W'(8)) begin
              if (state_q == ST_WR_DATA) begin
                sda_t_d = 1'b0;
              end else if (addr_match_c) begin
                sda_t_d = 1'b0;
                busy_d  = 1'b1;
                rw_d    = shift_q[0];
                first_d = 1'b1;
              end
            end
          end
        end
        ST_ADDR_ACK: begin
          // Prefetch is harmless for writes: the shifter is refilled by data bits.
          if (scl_rise) begin
            bit_cnt_d = '0;
            shift_d   = mem_q[offset_q];
          end
        end
        ST_WR_ACK: begin
          if (scl_rise) begin
            bit_cnt_d = '0;
            if (first_q) begin
              offset_d = shift_q;
              first_d  = 1'b0;
            end else begin
              offset_d = offset_inc_c;
`ifdef DDC_I2C_WRITE_EN
              i2c_we_c = 1'b1;
`endif
            end
          end
        end
        ST_RD_DATA: begin
          if (scl_fall) begin
            if (bit_cnt_q == BCNT_W'(8)) begin
              sda_t_d = 1'b1;
            end else begin
              sda_t_d   = shift_q[7];
              shift_d   = {shift_q[6:0], 1'b0};
              bit_cnt_d = bit_cnt_q + BCNT_W'(1);
            end
          end
        end
        ST_RD_ACK: begin
          // Offset advances past every byte sent; only ACK continues the burst.
          if (scl_rise) begin
            bit_cnt_d = '0;
            offset_d  = offset_inc_c;
            shift_d   = mem_q[offset_inc_c];
          end
        end
        default: sda_t_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge aclk_i) begin
    if (rst_i) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
      offset_q  <= '0;
      rw_q      <= 1'b0;
      first_q   <= 1'b0;
      sda_t_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      offset_q  <= offset_d;
      rw_q      <= rw_d;
      first_q   <= first_d;
      sda_t_q   <= sda_t_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // EDID image; the host write is issued last so it wins on an address clash.
  always_ff @(posedge aclk_i) begin
`ifdef DDC_I2C_WRITE_EN
    if (i2c_we_c) mem_q[offset_q] <= shift_q;
`endif
    if (mem_we_i) mem_q[mem_addr_i] <= mem_wdata_i;
  end

  assign i2c_sda_o   = 1'b0;
  assign i2c_sda_t_o = sda_t_q;
  assign busy_o      = busy_q;
  assign xfer_done_o = done_q;
  assign offset_o    = offset_q;

endmodule

// File: tb/tb_hdmi_ddc_edid_responder.sv
// Directed bench for hdmi_ddc_edid_responder: a bit-banged I2C initiator on a
// wired-AND SDA line, with hand-computed expectations (image byte i = i ^ 0xA5).
module tb_hdmi_ddc_edid_responder;

  localparam int Q = 20;  // quarter SCL period in clocks

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_bus;
  logic       dut_sda_o, dut_sda_t;
  logic       mem_we = 1'b0;
  logic [7:0] mem_addr = '0;
  logic [7:0] mem_wdata = '0;
  logic       busy, xfer_done;
  logic [7:0] offset;

  int tests_run = 0;
  int tests_failed = 0;
  int drive_cnt = 0;
  int busy_cnt = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  assign sda_bus = m_sda & (dut_sda_t | dut_sda_o);

  hdmi_ddc_edid_responder #(.DEV_ADDR(7'h50), .FILTER_LEN(3)) dut (
    .aclk_i(clk), .rst_i(rst),
    .i2c_scl_i(m_scl), .i2c_sda_i(sda_bus),
    .i2c_sda_o(dut_sda_o), .i2c_sda_t_o(dut_sda_t),
    .mem_we_i(mem_we), .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
    .busy_o(busy), .xfer_done_o(xfer_done), .offset_o(offset)
  );

  always @(negedge clk) begin
    if (!dut_sda_t) drive_cnt <= drive_cnt + 1;
    if (busy)       busy_cnt  <= busy_cnt + 1;
    if (xfer_done)  done_cnt  <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    m_sda = 1'b0; wait_clk(Q);
    m_scl = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_restart();
    m_sda = 1'b1; wait_clk(Q);
    m_scl = 1'b1; wait_clk(Q);
    i2c_start();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wait_clk(Q);
    m_scl = 1'b1; wait_clk(Q);
    m_sda = 1'b1; wait_clk(2 * Q);
  endtask

  // Optional 1-clock inverted SDA pulse while SCL is high.
  task automatic wr_bit(input logic b, input logic glitch);
    m_sda = b; wait_clk(Q);
    m_scl = 1'b1; wait_clk(Q);
    if (glitch) begin
      m_sda = ~b; wait_clk(1);
      m_sda = b;  wait_clk(Q - 1);
    end else begin
      wait_clk(Q);
    end
    m_scl = 1'b0; wait_clk(Q);
  endtask

  task automatic rd_bit(output logic b);
    m_sda = 1'b1; wait_clk(Q);
    m_scl = 1'b1; wait_clk(Q);
    b = sda_bus;  wait_clk(Q);
    m_scl = 1'b0; wait_clk(Q);
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) wr_bit(d[i], 1'b0);
    rd_bit(ack);
  endtask

  task automatic rd_byte(input logic ack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      rd_bit(b);
      d[i] = b;
    end
    wr_bit(ack, 1'b0);
  endtask

  // Offset write followed by a repeated-START read address phase.
  task automatic open_read(input logic [7:0] off, input string tag);
    logic ack;
    i2c_start();
    wr_byte(8'hA0, ack);  check({tag, "_aw_ack"}, 32'(ack), 32'd0);
    wr_byte(off, ack);    check({tag, "_off_ack"}, 32'(ack), 32'd0);
    i2c_restart();
    wr_byte(8'hA1, ack);  check({tag, "_ar_ack"}, 32'(ack), 32'd0);
  endtask

  initial begin
    logic       ack, b;
    logic [7:0] d;
    int         drv0, busy0, done0, lat;
    logic [7:0] exp_rb;

    wait_clk(5);
    rst = 1'b0;
    wait_clk(1);
    check("rst_sda_t", 32'(dut_sda_t), 32'd1);
    check("rst_sda_o", 32'(dut_sda_o), 32'd0);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_done",  32'(xfer_done), 32'd0);
    check("rst_offset", 32'(offset),   32'd0);

    for (int i = 0; i < 256; i++) begin
      mem_we = 1'b1; mem_addr = 8'(i); mem_wdata = 8'(i) ^ 8'hA5;
      wait_clk(1);
    end
    mem_we = 1'b0;
    wait_clk(10);

    // Offset 0x10, restart read of four bytes
    done0 = done_cnt;
    open_read(8'h10, "t1");
    check("t1_busy", 32'(busy), 32'd1);
    rd_byte(1'b0, d); check("t1_b0", 32'(d), 32'hB5);
    rd_byte(1'b0, d); check("t1_b1", 32'(d), 32'hB4);
    rd_byte(1'b0, d); check("t1_b2", 32'(d), 32'hB7);
    rd_byte(1'b1, d); check("t1_b3", 32'(d), 32'hB6);
    i2c_stop();
    check("t1_offset", 32'(offset), 32'h14);
    check("t1_done", 32'(done_cnt - done0), 32'd1);
    check("t1_busy_end", 32'(busy), 32'd0);

    // Wrong address: never ACKed, never busy
    drv0 = drive_cnt; busy0 = busy_cnt; done0 = done_cnt;
    i2c_start();
    wr_byte(8'hA2, ack);
    check("t2_nack", 32'(ack), 32'd1);
    i2c_stop();
    check("t2_no_drive", 32'(drive_cnt - drv0), 32'd0);
    check("t2_no_busy",  32'(busy_cnt - busy0), 32'd0);
    check("t2_no_done",  32'(done_cnt - done0), 32'd0);

    // Offset wrap
    open_read(8'hFE, "t3");
    rd_byte(1'b0, d); check("t3_b0", 32'(d), 32'h5B);
    rd_byte(1'b0, d); check("t3_b1", 32'(d), 32'h5A);
    rd_byte(1'b1, d); check("t3_b2", 32'(d), 32'hA5);
    i2c_stop();
    check("t3_offset", 32'(offset), 32'h01);

    // Data write then readback
    i2c_start();
    wr_byte(8'hA0, ack); check("t4_aw_ack", 32'(ack), 32'd0);
    wr_byte(8'h20, ack); check("t4_off_ack", 32'(ack), 32'd0);
    wr_byte(8'h3C, ack); check("t4_data_ack", 32'(ack), 32'd0);
    i2c_stop();
    check("t4_offset", 32'(offset), 32'h21);
`ifdef DDC_I2C_WRITE_EN
    exp_rb = 8'h3C;
`else
    exp_rb = 8'h85;
`endif
    open_read(8'h20, "t4r");
    rd_byte(1'b1, d); check("t4_readback", 32'(d), 32'(exp_rb));
    i2c_stop();

    // One-clock SDA glitches while SCL is high must not be seen as START/STOP
    done0 = done_cnt;
    i2c_start();
    wr_byte(8'hA0, ack); check("t5_aw_ack", 32'(ack), 32'd0);
    d = 8'h40;
    for (int i = 7; i >= 0; i--) wr_bit(d[i], (i == 6) || (i == 0));
    rd_bit(ack);
    check("t5_off_ack", 32'(ack), 32'd0);
    check("t5_busy", 32'(busy), 32'd1);
    check("t5_no_done", 32'(done_cnt - done0), 32'd0);
    i2c_restart();
    wr_byte(8'hA1, ack); check("t5_ar_ack", 32'(ack), 32'd0);
    rd_byte(1'b1, d); check("t5_rd", 32'(d), 32'hE5);
    i2c_stop();

    // STOP in the middle of a read byte (0xB5: bits 1,0 then released 1)
    done0 = done_cnt;
    open_read(8'h10, "t6");
    rd_bit(b); check("t6_bit7", 32'(b), 32'd1);
    rd_bit(b); check("t6_bit6", 32'(b), 32'd0);
    m_sda = 1'b0; wait_clk(Q);
    m_scl = 1'b1; wait_clk(Q);
    m_sda = 1'b1;
    lat = 0;
    while (busy && lat < 40) begin
      wait_clk(1);
      lat++;
    end
    check("t6_stop_seen", 32'(lat < 40), 32'd1);
    check("t6_sda_rel", 32'(dut_sda_t), 32'd1);
    wait_clk(2 * Q);
    check("t6_done", 32'(done_cnt - done0), 32'd1);
    check("t6_offset", 32'(offset), 32'h10);

    // Reset while driving a low read bit
    open_read(8'h10, "t7");
    rd_bit(b); check("t7_bit7", 32'(b), 32'd1);
    check("t7_driving", 32'(dut_sda_t), 32'd0);
    rst = 1'b1;
    wait_clk(1);
    check("t7_rst_sda_rel", 32'(dut_sda_t), 32'd1);
    check("t7_rst_offset", 32'(offset), 32'd0);
    check("t7_rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    m_sda = 1'b1; wait_clk(Q);
    m_scl = 1'b1; wait_clk(2 * Q);
    i2c_start();
    wr_byte(8'hA1, ack); check("t7_new_ack", 32'(ack), 32'd0);
    rd_byte(1'b1, d);    check("t7_new_rd", 32'(d), 32'hA5);
    i2c_stop();
    check("t7_new_offset", 32'(offset), 32'h01);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
